// File: rtl/feature_sum_accum.sv
`default_nettype none
// =============================================================================
// Module      : feature_sum_accum
// Description : Integral-image corner reader and weighted rect-sum accumulator
//               producing one signed feature sum per feature.
// Revision    : 1.0
// =============================================================================
module feature_sum_accum #(
  parameter int W_ADDR   = 10,
  parameter int W_II     = 18,
  parameter int W_WEIGHT = 8,
  parameter int W_FEAT   = W_II + W_WEIGHT + 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       addr_valid,
  output logic                       addr_ready,
  input  logic [W_ADDR-1:0]          addr_data,
  input  logic [1:0]                 addr_eot,
  input  logic                       wght_valid,
  output logic                       wght_ready,
  input  logic signed [W_WEIGHT-1:0] wght_data,
  output logic                       mem_en,
  output logic [W_ADDR-1:0]          mem_addr,
  input  logic [W_II-1:0]            mem_rdata,
  output logic                       feat_valid,
  input  logic                       feat_ready,
  output logic signed [W_FEAT-1:0]   feat_data,
  output logic                       err
);

  localparam int W_RECT = W_II + 2;
  localparam int W_PROD = W_RECT + W_WEIGHT;

  logic                       addr_hs;
  logic                       feat_hs;
  logic                       busy_eff;
  logic                       rect_close;
  logic                       feat_close;

  logic [1:0]                 corner_q, corner_d;
  logic [1:0]                 rect_cnt_q, rect_cnt_d;
  logic signed [W_WEIGHT-1:0] weight_q, weight_d;
  logic                       busy_q, busy_d;
  logic                       err_q, err_d;

  logic                       rd_vld_q, rd_vld_d;
  logic                       rd_neg_q, rd_neg_d;
  logic                       rd_last_q, rd_last_d;
  logic                       rd_feat_q, rd_feat_d;
  logic signed [W_RECT-1:0]   rect_acc_q, rect_acc_d;

  logic                       sum_vld_q, sum_vld_d;
  logic                       sum_feat_q, sum_feat_d;
  logic signed [W_RECT-1:0]   rect_sum_q, rect_sum_d;
  logic signed [W_WEIGHT-1:0] rect_wght_q, rect_wght_d;

  logic signed [W_FEAT-1:0]   feat_acc_q, feat_acc_d;
  logic signed [W_FEAT-1:0]   feat_data_q, feat_data_d;
  logic                       feat_valid_q, feat_valid_d;

  logic signed [W_RECT-1:0]   rdata_ext;
  logic signed [W_RECT-1:0]   rect_next;
  logic signed [W_PROD-1:0]   prod;
  logic signed [W_FEAT-1:0]   feat_next;

  // Releasing busy on the output handshake lets a new corner be taken in that same cycle.
  assign feat_hs    = feat_valid_q && feat_ready;
  assign busy_eff   = busy_q && !feat_hs;
  assign addr_ready = rst && !busy_eff && ((corner_q != 2'd0) || wght_valid);
  assign addr_hs    = addr_valid && addr_ready;
  assign wght_ready = addr_hs && (corner_q == 2'd0);
  assign mem_en     = addr_hs;
  assign mem_addr   = addr_hs ? addr_data : '0;

  // A feature end without a rect end still closes the rect so the feature cannot stall.
  assign rect_close = addr_hs && (addr_eot[0] || addr_eot[1]);
  assign feat_close = addr_hs && addr_eot[1];

  assign rdata_ext  = $signed({2'b00, mem_rdata});
  assign rect_next  = rd_neg_q ? (rect_acc_q - rdata_ext) : (rect_acc_q + rdata_ext);
  assign prod       = rect_sum_q * rect_wght_q;
  assign feat_next  = feat_acc_q + W_FEAT'(prod);

  assign feat_valid = feat_valid_q;
  assign feat_data  = feat_data_q;
  assign err        = err_q;

  always_comb begin
    corner_d   = corner_q;
    rect_cnt_d = rect_cnt_q;
    weight_d   = weight_q;
    busy_d     = busy_q;
    err_d      = err_q;

    if (addr_hs) begin
      if (corner_q == 2'd0) begin
        weight_d = wght_data;
      end
      if (rect_close) begin
        corner_d = 2'd0;
        if ((corner_q != 2'd3) || !addr_eot[0]) begin
          err_d = 1'b1;
        end
        if (rect_cnt_q == 2'd3) begin
          err_d = 1'b1;
        end
        if (feat_close) begin
          rect_cnt_d = 2'd0;
        end else if (rect_cnt_q != 2'd3) begin
          rect_cnt_d = rect_cnt_q + 2'd1;
        end
      end else begin
        corner_d = corner_q + 2'd1;
        if (corner_q == 2'd3) begin
          err_d = 1'b1;
        end
      end
    end

    if (feat_close) begin
      busy_d = 1'b1;
    end else if (feat_hs) begin
      busy_d = 1'b0;
    end
  end

  // Corners 1 and 2 are subtracted: sign pattern + - - +.
  always_comb begin
    rd_vld_d    = addr_hs;
    rd_neg_d    = corner_q[0] ^ corner_q[1];
    rd_last_d   = rect_close;
    rd_feat_d   = feat_close;
    rect_acc_d  = rect_acc_q;
    rect_sum_d  = rect_sum_q;
    rect_wght_d = rect_wght_q;
    sum_vld_d   = rd_vld_q && rd_last_q;
    sum_feat_d  = rd_feat_q;

    if (rd_vld_q) begin
      if (rd_last_q) begin
        rect_sum_d  = rect_next;
        rect_wght_d = weight_q;
        rect_acc_d  = '0;
      end else begin
        rect_acc_d  = rect_next;
      end
    end
  end

  always_comb begin
    feat_acc_d   = feat_acc_q;
    feat_data_d  = feat_data_q;
    feat_valid_d = feat_valid_q;

    if (feat_hs) begin
      feat_valid_d = 1'b0;
    end
    if (sum_vld_q) begin
      if (sum_feat_q) begin
        feat_data_d  = feat_next;
        feat_valid_d = 1'b1;
        feat_acc_d   = '0;
      end else begin
        feat_acc_d   = feat_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      corner_q     <= '0;
      rect_cnt_q   <= '0;
      weight_q     <= '0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      rd_vld_q     <= 1'b0;
      rd_neg_q     <= 1'b0;
      rd_last_q    <= 1'b0;
      rd_feat_q    <= 1'b0;
      rect_acc_q   <= '0;
      sum_vld_q    <= 1'b0;
      sum_feat_q   <= 1'b0;
      rect_sum_q   <= '0;
      rect_wght_q  <= '0;
      feat_acc_q   <= '0;
      feat_data_q  <= '0;
      feat_valid_q <= 1'b0;
    end else begin
      corner_q     <= corner_d;
      rect_cnt_q   <= rect_cnt_d;
      weight_q     <= weight_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      rd_vld_q     <= rd_vld_d;
      rd_neg_q     <= rd_neg_d;
      rd_last_q    <= rd_last_d;
      rd_feat_q    <= rd_feat_d;
      rect_acc_q   <= rect_acc_d;
      sum_vld_q    <= sum_vld_d;
      sum_feat_q   <= sum_feat_d;
      rect_sum_q   <= rect_sum_d;
      rect_wght_q  <= rect_wght_d;
      feat_acc_q   <= feat_acc_d;
      feat_data_q  <= feat_data_d;
      feat_valid_q <= feat_valid_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_feature_sum_accum.sv
`default_nettype none
// =============================================================================
// Module      : tb_feature_sum_accum
// Description : Directed self-checking bench with an expected-sum scoreboard.
// Revision    : 1.0
// =============================================================================
module tb_feature_sum_accum;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               addr_valid = 1'b0;
  logic               addr_ready;
  logic [9:0]         addr_data = '0;
  logic [1:0]         addr_eot = '0;
  logic               wght_valid = 1'b0;
  logic               wght_ready;
  logic signed [7:0]  wght_data = '0;
  logic               mem_en;
  logic [9:0]         mem_addr;
  logic [17:0]        mem_rdata = '0;
  logic               feat_valid;
  logic               feat_ready = 1'b1;
  logic signed [28:0] feat_data;
  logic               err;

  logic [17:0]        mem [0:1023];
  logic signed [28:0] exp_q [$];
  logic signed [28:0] last_exp;
  longint             acc = 0;
  int                 n_tests = 0;
  int                 n_fail = 0;

  feature_sum_accum dut (
    .clk        (clk),
    .rst        (rst),
    .addr_valid (addr_valid),
    .addr_ready (addr_ready),
    .addr_data  (addr_data),
    .addr_eot   (addr_eot),
    .wght_valid (wght_valid),
    .wght_ready (wght_ready),
    .wght_data  (wght_data),
    .mem_en     (mem_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .feat_valid (feat_valid),
    .feat_ready (feat_ready),
    .feat_data  (feat_data),
    .err        (err)
  );

  always #5 clk = ~clk;

  // One-cycle read latency integral-image memory.
  always @(posedge clk) begin
    if (mem_en) mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic corner(input logic [9:0] a, input logic [1:0] eot, input logic wv, input logic signed [7:0] w);
    int guard;
    guard = 0;
    @(negedge clk);
    addr_valid = 1'b1; addr_data = a; addr_eot = eot; wght_valid = wv; wght_data = w;
    #1;
    while (!addr_ready && guard < 40) begin
      @(negedge clk); #1; guard++;
    end
    if (guard >= 40) check("corner_accept_timeout", addr_ready, 1);
    @(posedge clk); #1;
    addr_valid = 1'b0; wght_valid = 1'b0; addr_eot = 2'b00;
  endtask

  task automatic send_rect(input int base, input int v0, input int v1, input int v2, input int v3,
                           input int w, input bit last);
    mem[base]   = 18'(v0);
    mem[base+1] = 18'(v1);
    mem[base+2] = 18'(v2);
    mem[base+3] = 18'(v3);
    corner(10'(base),   2'b00, 1'b1, 8'(w));
    corner(10'(base+1), 2'b00, 1'b0, 8'sd0);
    corner(10'(base+2), 2'b00, 1'b0, 8'sd0);
    corner(10'(base+3), {last, 1'b1}, 1'b0, 8'sd0);
    acc += longint'(v0 - v1 - v2 + v3) * longint'(w);
    if (last) begin
      exp_q.push_back(29'(acc));
      acc = 0;
    end
  endtask

  // Called right after the last corner; exp_lat counts clock edges until feat_valid.
  task automatic expect_feat(input string tag, input int exp_lat);
    int n;
    logic signed [28:0] e;
    n = 0;
    while (!feat_valid && n < 30) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_valid"}, feat_valid, 1);
    if (exp_lat >= 0) check({tag, "_latency"}, n, exp_lat);
    if (exp_q.size() != 0) e = exp_q.pop_front();
    else e = 'x;
    last_exp = e;
    check({tag, "_data"}, feat_data, e);
  endtask

  initial begin
    // Reset state, with inputs that would otherwise raise ready/enable
    addr_valid = 1'b1; wght_valid = 1'b1; addr_data = 10'd5;
    repeat (3) @(negedge clk);
    #1;
    check("rst_addr_ready", addr_ready, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_feat_valid", feat_valid, 0);
    check("rst_feat_data", feat_data, 0);
    check("rst_err", err, 0);
    @(negedge clk);
    addr_valid = 1'b0; wght_valid = 1'b0; rst = 1'b1;

    // 1: two rects, (10-4-3+1)*-1 + (20-5-5+2)*2 = 20
    send_rect(100, 10, 4, 3, 1, -1, 1'b0);
    send_rect(110, 20, 5, 5, 2, 2, 1'b1);
    check("t1_no_valid_early", feat_valid, 0);
    expect_feat("t1", 2);
    check("t1_spec_value", feat_data, 20);
    @(posedge clk); #1;
    check("t1_valid_drop", feat_valid, 0);
    check("t1_err", err, 0);

    // 2: three rects, sums 7,5,9 with weights 3,-2,1
    send_rect(200, 10, 2, 3, 2, 3, 1'b0);
    send_rect(210, 8, 1, 3, 1, -2, 1'b0);
    send_rect(220, 12, 1, 4, 2, 1, 1'b1);
    expect_feat("t2", 2);
    check("t2_spec_value", feat_data, 20);
    check("t2_err", err, 0);
    @(posedge clk); #1;

    // 3: downstream stall holds the result and blocks new corners
    feat_ready = 1'b0;
    send_rect(300, 30, 6, 7, 2, 1, 1'b0);
    send_rect(310, 9, 1, 2, 1, -3, 1'b1);
    expect_feat("t3", 2);
    @(negedge clk);
    addr_valid = 1'b1; addr_data = 10'd400; wght_valid = 1'b1; wght_data = 8'sd5;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("t3_hold_addr_ready", addr_ready, 0);
      check("t3_hold_mem_en", mem_en, 0);
      check("t3_hold_valid", feat_valid, 1);
      check("t3_hold_data", feat_data, last_exp);
      @(negedge clk);
    end
    addr_valid = 1'b0; feat_ready = 1'b1;
    #1;
    check("t3_ready_same_cycle", addr_ready, 1);
    @(posedge clk); #1;
    wght_valid = 1'b0;
    check("t3_valid_drop", feat_valid, 0);
    send_rect(320, 40, 10, 12, 3, -4, 1'b0);
    send_rect(330, 15, 2, 6, 4, 5, 1'b1);
    expect_feat("t3_next", 2);
    @(posedge clk); #1;

    // 4: corner 0 stalls without a weight, then takes both together
    mem[500] = 18'd25; mem[501] = 18'd7; mem[502] = 18'd6; mem[503] = 18'd1;
    @(negedge clk);
    addr_valid = 1'b1; addr_data = 10'd500; addr_eot = 2'b00; wght_valid = 1'b0; wght_data = -8'sd3;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t4_no_weight_ready", addr_ready, 0);
      check("t4_no_weight_mem_en", mem_en, 0);
      check("t4_no_weight_wready", wght_ready, 0);
      @(negedge clk);
    end
    wght_valid = 1'b1;
    #1;
    check("t4_addr_ready", addr_ready, 1);
    check("t4_wght_ready", wght_ready, 1);
    check("t4_mem_en", mem_en, 1);
    check("t4_mem_addr", mem_addr, 500);
    @(posedge clk); #1;
    addr_valid = 1'b0; wght_valid = 1'b0;
    corner(10'd501, 2'b00, 1'b0, 8'sd0);
    corner(10'd502, 2'b00, 1'b0, 8'sd0);
    corner(10'd503, 2'b01, 1'b0, 8'sd0);
    acc += longint'(25 - 7 - 6 + 1) * -3;
    send_rect(510, 9, 3, 2, 1, 2, 1'b1);
    expect_feat("t4", 2);
    check("t4_err", err, 0);
    @(posedge clk); #1;

    // 5: rect ended early on corner 2 -> sticky error, partial rect still summed
    mem[600] = 18'd50; mem[601] = 18'd10; mem[602] = 18'd5;
    corner(10'd600, 2'b00, 1'b1, 8'sd2);
    corner(10'd601, 2'b00, 1'b0, 8'sd0);
    corner(10'd602, 2'b11, 1'b0, 8'sd0);
    exp_q.push_back(29'sd70);
    check("t5_err_set", err, 1);
    expect_feat("t5", 2);
    @(posedge clk); #1;
    send_rect(610, 33, 4, 8, 2, 3, 1'b0);
    send_rect(620, 17, 9, 1, 5, -1, 1'b1);
    expect_feat("t5_next", 2);
    check("t5_err_sticky", err, 1);
    @(posedge clk); #1;

    // 6: reset in the middle of a feature
    send_rect(700, 11, 2, 3, 1, 4, 1'b0);
    mem[710] = 18'd9;
    corner(10'd710, 2'b00, 1'b1, 8'sd1);
    acc = 0;
    @(negedge clk);
    addr_valid = 1'b1; addr_data = 10'd711; wght_valid = 1'b1; rst = 1'b0;
    #1;
    check("t6_addr_ready", addr_ready, 0);
    check("t6_wght_ready", wght_ready, 0);
    check("t6_mem_en", mem_en, 0);
    check("t6_mem_addr", mem_addr, 0);
    check("t6_feat_valid", feat_valid, 0);
    check("t6_feat_data", feat_data, 0);
    check("t6_err", err, 0);
    @(negedge clk);
    addr_valid = 1'b0; wght_valid = 1'b0; rst = 1'b1;
    send_rect(720, 100, 20, 30, 5, 7, 1'b0);
    send_rect(730, 60, 15, 10, 3, -6, 1'b1);
    expect_feat("t6", 2);
    check("t6_err_after", err, 0);
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
